// File: rtl/issue_ctrl_if.sv
// issue_ctrl_if: fetch, decode, execute and writeback signals
// around the issue controller, with DUT-side and driver-side views.
interface issue_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              f_valid_i;
  logic [AWIDTH-1:0] f_pc_i;
  logic [DWIDTH-1:0] f_insn_i;
  logic              f_ready_o;
  logic [AWIDTH-1:0] dec_pc_o;
  logic [DWIDTH-1:0] dec_insn_o;
  logic [6:0]        dec_opcode_i;
  logic [4:0]        dec_rd_i;
  logic [4:0]        dec_rs1_i;
  logic [4:0]        dec_rs2_i;
  logic              e_valid_o;
  logic              e_ready_i;
  logic [AWIDTH-1:0] e_pc_o;
  logic [DWIDTH-1:0] e_insn_o;
  logic              e_illegal_o;
  logic              wb_valid_i;
  logic [4:0]        wb_rd_i;
  logic              flush_i;
  logic [31:0]       stall_cnt_o;

  modport slave (
    input  f_valid_i, f_pc_i, f_insn_i,
    input  dec_opcode_i, dec_rd_i,
    input  dec_rs1_i, dec_rs2_i,
    input  e_ready_i, wb_valid_i, wb_rd_i,
    input  flush_i,
    output f_ready_o, dec_pc_o, dec_insn_o,
    output e_valid_o, e_pc_o, e_insn_o,
    output e_illegal_o, stall_cnt_o
  );

  modport master (
    output f_valid_i, f_pc_i, f_insn_i,
    output dec_opcode_i, dec_rd_i,
    output dec_rs1_i, dec_rs2_i,
    output e_ready_i, wb_valid_i, wb_rd_i,
    output flush_i,
    input  f_ready_o, dec_pc_o, dec_insn_o,
    input  e_valid_o, e_pc_o, e_insn_o,
    input  e_illegal_o, stall_cnt_o
  );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl: single-entry issue stage between fetch and execute,
// interlocked by a per-register scoreboard of outstanding writes.
module issue_ctrl #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  issue_ctrl_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic              hold_valid;
  logic [AWIDTH-1:0] hold_pc;
  logic [DWIDTH-1:0] hold_insn;
  logic [31:0]       busy;
  logic [31:0]       busy_eff;
  logic [31:0]       busy_nxt;
  logic [31:0]       wb_clr;
  logic [31:0]       stall_cnt;
  logic              use_rs1;
  logic              use_rs2;
  logic              use_rd;
  logic              illegal;
  logic              hz_rs1;
  logic              hz_rs2;
  logic              hz_rd;
  logic              hazard;
  logic              e_valid;
  logic              fire;
  logic              f_ready;
  logic              accept;
  logic              stalled;

  // Register-use classification of the held opcode
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      bus.dec_opcode_i == OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      bus.dec_opcode_i == OP_IMM,
      bus.dec_opcode_i == OP_LD,
      bus.dec_opcode_i == OP_JALR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      bus.dec_opcode_i == OP_ST,
      bus.dec_opcode_i == OP_BR: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      bus.dec_opcode_i == OP_JAL,
      bus.dec_opcode_i == OP_LUI,
      bus.dec_opcode_i == OP_AUIPC: begin
        use_rd = 1'b1;
      end
      bus.dec_opcode_i == OP_SYS: begin
        illegal = 1'b0;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // A same-cycle writeback releases its register before the check
  assign wb_clr = bus.wb_valid_i
                ? (32'd1 << bus.wb_rd_i) : 32'd0;
  assign busy_eff = busy & ~wb_clr;

  assign hz_rs1 = use_rs1 && (bus.dec_rs1_i != 5'd0)
               && busy_eff[bus.dec_rs1_i];
  assign hz_rs2 = use_rs2 && (bus.dec_rs2_i != 5'd0)
               && busy_eff[bus.dec_rs2_i];
  assign hz_rd  = use_rd && (bus.dec_rd_i != 5'd0)
               && busy_eff[bus.dec_rd_i];
  assign hazard = hz_rs1 || hz_rs2 || hz_rd;

  assign e_valid = hold_valid && !hazard && !bus.flush_i;
  assign fire    = e_valid && bus.e_ready_i;
  assign f_ready = rst && !bus.flush_i
                && (!hold_valid || fire);
  assign accept  = bus.f_valid_i && f_ready;
  assign stalled = hold_valid && hazard && !bus.flush_i;

  // Scoreboard update: clear on writeback, then set on issue
  always_comb begin
    busy_nxt = busy & ~wb_clr;
    if (fire && use_rd) begin
      busy_nxt[bus.dec_rd_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Holding register: load on accept, drop on issue or flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_pc    <= '0;
      hold_insn  <= '0;
    end else if (bus.flush_i) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_pc    <= bus.f_pc_i;
      hold_insn  <= bus.f_insn_i;
    end else if (fire) begin
      hold_valid <= 1'b0;
    end
  end

  // Outstanding-write bits; kept across flush for older writebacks
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Saturating count of hazard stall cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.f_ready_o   = f_ready;
  assign bus.e_valid_o   = e_valid;
  assign bus.e_illegal_o = illegal;
  assign bus.e_pc_o      = hold_pc;
  assign bus.e_insn_o    = hold_insn;
  assign bus.dec_pc_o    = hold_pc;
  assign bus.dec_insn_o  = hold_insn;
  assign bus.stall_cnt_o = stall_cnt;
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Issue controller between fetch and execute.
- Holds one fetched instruction in a holding register and drives it into the decode stage.
- Consumes the decoded register fields from decode and keeps a per-register scoreboard of outstanding writes.
- Issues to execute only when no RAW/WAW hazard exists, using valid/ready handshakes on both sides; supports flush on redirect and counts hazard stall cycles.

Parameters:
- DWIDTH, 32, instruction/data width.
- AWIDTH, 32, PC width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (one clock domain; sampled on rising clk)
- f_valid_i  in  1  fetch has instruction
- f_pc_i  in  AWIDTH  fetch PC
- f_insn_i  in  DWIDTH  fetch instruction
- f_ready_o  out  1  controller accepts fetch this cycle
- dec_pc_o  out  AWIDTH  held PC, to decode pc_i
- dec_insn_o  out  DWIDTH  held instruction, to decode insn_i
- dec_opcode_i  in  7  from decode
- dec_rd_i  in  5  from decode
- dec_rs1_i  in  5  from decode
- dec_rs2_i  in  5  from decode
- e_valid_o  out  1  issue valid
- e_ready_i  in  1  execute accepts
- e_pc_o  out  AWIDTH  issued PC
- e_insn_o  out  DWIDTH  issued instruction
- e_illegal_o  out  1  held opcode not in supported set
- wb_valid_i  in  1  writeback retires a register write
- wb_rd_i  in  5  writeback destination
- flush_i  in  1  redirect; drop held instruction
- stall_cnt_o  out  32  saturating hazard-stall cycle count

Behaviour:
- Reset (rst==0 at posedge):
  - hold_valid=0, hold_pc=0, hold_insn=0, busy[31:0]=0, stall_cnt_o=0.
  - Consequently e_valid_o=0, e_pc_o/e_insn_o/dec_*_o=0, f_ready_o=0 while rst low.
  - Reset mid-operation discards the held instruction and all busy bits.
- States derived from hold_valid and hazard:
  - EMPTY: !hold_valid.
  - HOLD: hold_valid && !hazard.
  - STALL: hold_valid && hazard.
- Register-use table by opcode:
  - 0110011: rs1, rs2, rd.
  - 0010011, 0000011, 1100111: rs1, rd.
  - 0100011, 1100011: rs1, rs2.
  - 1101111, 0110111, 0010111: rd.
  - 1110011: none.
  - Any other opcode: none, and e_illegal_o=1.
- busy_eff = busy & ~(wb_valid_i ? onehot(wb_rd_i) : 0). A writeback releases its register in the same cycle.
- hazard = (uses_rs1 && rs1!=0 && busy_eff[rs1]) || (uses_rs2 && rs2!=0 && busy_eff[rs2]) || (uses_rd && rd!=0 && busy_eff[rd]). The rd term is the WAW check.
- Combinational outputs:
  - e_valid_o = hold_valid && !hazard && !flush_i.
  - fire = e_valid_o && e_ready_i.
  - f_ready_o = rst && !flush_i && (!hold_valid || fire).
  - e_pc_o/e_insn_o/dec_pc_o/dec_insn_o = hold_pc/hold_insn.
- Holding register:
  - On f_valid_i && f_ready_o: load f_pc_i/f_insn_i, hold_valid=1.
  - Else on fire: hold_valid=0.
  - Latency: accepted at edge N, e_valid_o may assert in cycle N+1.
  - Back-to-back issue at one instruction per cycle.
- Scoreboard next state, in order:
  - Clear wb_rd_i if wb_valid_i.
  - Then set rd if fire && uses_rd && rd!=0. Set wins over a same-cycle clear of the same register.
  - busy[0] is always 0.
  - wb_valid_i for a non-busy register is ignored.
- Backpressure: while e_valid_o && !e_ready_i, hold contents remain stable and f_ready_o=0.
- Flush:
  - flush_i forces e_valid_o=0 and f_ready_o=0 that cycle; hold_valid=0 next cycle.
  - Busy bits are NOT cleared, because older issued instructions still write back.
  - Writeback during flush is still applied.
- stall_cnt_o increments by 1 each cycle in STALL with flush_i=0 and saturates at 0xFFFFFFFF. Backpressure cycles are not counted.

Test Plan:
- Reset: hold rst=0 for 2 cycles with f_valid_i=1 -> f_ready_o=0, e_valid_o=0, stall_cnt_o=0. After release f_ready_o=1 and nothing is issued before an accept.
- Independent stream: ADD x5,x6,x7 (0x007302B3) at pc 0x0, then XOR x8,x9,x10 at pc 0x4, with e_ready_i=1 -> issued in consecutive cycles N+1, N+2; busy[5] and busy[8] set; stall_cnt_o=0.
- RAW stall: issue 0x007302B3, then SUB x6,x5,x7 (0x40728333) -> e_valid_o=0 and stall_cnt_o counts 1,2,3. Assert wb_valid_i with wb_rd_i=5 in cycle 4 -> SUB issues that same cycle, busy[5]=0, busy[6]=1.
- x0 handling: ADD x0,x0,x0 (0x00000033) with busy[0] forced conditions -> issues immediately, no busy bit set; opcode 0x7F -> issues with e_illegal_o=1.
- Backpressure: e_ready_i=0 for 3 cycles with valid held -> e_pc_o/e_insn_o stable, f_ready_o=0, stall_cnt_o unchanged; e_ready_i=1 -> issue, and the next fetch is accepted the same cycle.
- Flush in STALL: flush_i=1 one cycle -> e_valid_o=0, hold dropped, busy bits retained, stall_cnt_o not incremented; next fetch accepted the following cycle.
